// File: rtl/io_map_pkg.sv
// io_map_pkg: shared address map and field positions for the data-side bus
// bridge and its timer.
//   IO_BASE       : base of the 256-byte memory-mapped IO window
//   OFF_*         : byte offsets of the IO registers inside that window
//   CTRL_*/STAT_* : bit positions inside TMR_CTRL / TMR_STAT
//   tmr_we_t      : decoded per-register write strobes handed to io_timer
package io_map_pkg;

  localparam logic [31:0] IO_BASE = 32'hFFFF_FF00;

  localparam logic [7:0] OFF_GPIO_OUT  = 8'h00;
  localparam logic [7:0] OFF_GPIO_IN   = 8'h04;
  localparam logic [7:0] OFF_TMR_CTRL  = 8'h08;
  localparam logic [7:0] OFF_TMR_LOAD  = 8'h0C;
  localparam logic [7:0] OFF_TMR_COUNT = 8'h10;
  localparam logic [7:0] OFF_TMR_STAT  = 8'h14;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_IE  = 1;
  localparam int CTRL_AR  = 2;
  localparam int STAT_EXP = 0;

  typedef struct packed {
    logic ctrl;
    logic load;
    logic stat;
  } tmr_we_t;

endpackage

// File: rtl/io_timer.sv
// io_timer: 32-bit down-counting timer with sticky expiry flag.
//   clk, rst   : clock, async active-low reset
//   we, wdata  : decoded register write strobes and store data
//   ctrl       : {AR, IE, EN}
//   load/count : reload value and live counter
//   exp, irq   : sticky expiry flag and interrupt (EXP & IE, flop-driven)
module io_timer
  import io_map_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  tmr_we_t     we,
  input  logic [31:0] wdata,
  output logic [2:0]  ctrl,
  output logic [31:0] load,
  output logic [31:0] count,
  output logic        exp,
  output logic        irq
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl  <= '0;
      load  <= '0;
      count <= '0;
      exp   <= 1'b0;
    end else begin
      if (we.ctrl) ctrl <= wdata[2:0];
      if (we.load) load <= wdata;
      if (we.stat && wdata[STAT_EXP]) exp <= 1'b0;

      // Later assignments below override the ones above: expiry sets EXP
      // even when a clear lands on the same edge, while a CTRL write keeps
      // priority over the one-shot auto-disable.
      if (we.load) begin
        count <= wdata;
      end else if (ctrl[CTRL_EN]) begin
        if (count != 32'd0) begin
          count <= count - 32'd1;
        end else begin
          exp <= 1'b1;
          if (ctrl[CTRL_AR]) count <= load;
          else if (!we.ctrl) ctrl[CTRL_EN] <= 1'b0;
        end
      end
    end
  end

  // Both terms are flops, so nothing from the core's bus reaches INT
  // combinationally.
  assign irq = exp & ctrl[CTRL_IE];

endmodule

// File: rtl/io_bus_bridge.sv
// io_bus_bridge: decodes core data-port accesses into data RAM or a small IO
// window (GPIO + timer). Reads are fully combinational so the core's MDR can
// sample them in the same cycle.
//   clk, rst                 : clock, async active-low reset
//   cpu_addr/wdata/we/rdata  : core data port
//   ram_addr/wdata/we/rdata  : data RAM (async read)
//   gpio_out, gpio_in        : GPIO register and raw external pins
//   irq                      : timer interrupt to core INT
module io_bus_bridge
  import io_map_pkg::*;
#(
  parameter int RAM_AW = 10,
  parameter int GPIO_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic              cpu_we,
  output logic [31:0]       cpu_rdata,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_we,
  input  logic [31:0]       ram_rdata,
  output logic [GPIO_W-1:0] gpio_out,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic              irq
);

  logic              ram_hit, io_hit, io_we;
  logic [7:0]        io_off;
  logic [GPIO_W-1:0] sync1, sync2;
  tmr_we_t           tmr_we;
  logic [2:0]        tmr_ctrl;
  logic [31:0]       tmr_load, tmr_count;
  logic              tmr_exp;

  // Byte lanes are not supported; the low address bits are don't-care.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^cpu_addr[1:0];

  assign ram_hit = (cpu_addr[31:RAM_AW+2] == '0);
  assign io_hit  = (cpu_addr[31:8] == IO_BASE[31:8]);
  assign io_off  = {cpu_addr[7:2], 2'b00};
  assign io_we   = cpu_we & io_hit;

  assign ram_addr  = cpu_addr[RAM_AW+1:2];
  assign ram_wdata = cpu_wdata;
  assign ram_we    = cpu_we & ram_hit;

  assign tmr_we.ctrl = io_we && (io_off == OFF_TMR_CTRL);
  assign tmr_we.load = io_we && (io_off == OFF_TMR_LOAD);
  assign tmr_we.stat = io_we && (io_off == OFF_TMR_STAT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpio_out <= '0;
      sync1    <= '0;
      sync2    <= '0;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
      if (io_we && (io_off == OFF_GPIO_OUT)) gpio_out <= cpu_wdata[GPIO_W-1:0];
    end
  end

  io_timer u_timer (
    .clk   (clk),
    .rst   (rst),
    .we    (tmr_we),
    .wdata (cpu_wdata),
    .ctrl  (tmr_ctrl),
    .load  (tmr_load),
    .count (tmr_count),
    .exp   (tmr_exp),
    .irq   (irq)
  );

  always_comb begin
    cpu_rdata = '0;
    if (ram_hit) begin
      cpu_rdata = ram_rdata;
    end else if (io_hit) begin
      case (io_off)
        OFF_GPIO_OUT:  cpu_rdata = 32'(gpio_out);
        OFF_GPIO_IN:   cpu_rdata = 32'(sync2);
        OFF_TMR_CTRL:  cpu_rdata = 32'(tmr_ctrl);
        OFF_TMR_LOAD:  cpu_rdata = tmr_load;
        OFF_TMR_COUNT: cpu_rdata = tmr_count;
        OFF_TMR_STAT:  cpu_rdata = 32'(tmr_exp);
        default:       cpu_rdata = '0;
      endcase
    end
  end

endmodule
